// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTxx/MFxx service.
// Latency: 33 cycles accept-to-writeback for every arithmetic op (32 iterations + FIX); moves take 1 edge.
// Backpressure: MDstall holds any md-class instruction in EX while busy; ExHold blocks accept only.
//
// Ports:
//   clk, rst_n           pipeline clock, async active-low reset
//   I2, I2Valid          stage-3 instruction word and its valid bit
//   ExHold               pipeline freeze from another cause (no accept while high)
//   RSbus, RTbus         rs / rt operands
//   MDresult             HI (MFHI) / LO (MFLO) / 0, combinational
//   MDbusy, MDstall      operation in flight / stall request to the pipeline
module muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] I2,
    input  logic        I2Valid,
    input  logic        ExHold,
    input  logic [31:0] RSbus,
    input  logic [31:0] RTbus,
    output logic [31:0] MDresult,
    output logic        MDbusy,
    output logic        MDstall
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state;
    logic [31:0] hi, lo;
    logic [31:0] a;        // multiplicand, or dividend shifting out MSB first
    logic [31:0] b;        // multiplier shifting out LSB first, or divisor
    logic [63:0] acc;      // product, or {remainder, quotient}
    logic [4:0]  cnt;
    logic        neg_q, neg_r, dz, div_op;

    // ---------------- decode ----------------
    logic [5:0] funct;
    logic       special, is_mfhi, is_mthi, is_mflo, is_mtlo, is_arith, md_class, accept;
    logic       op_signed;

    assign funct     = I2[5:0];
    assign special   = (I2[31:26] == 6'd0);
    assign is_mfhi   = special && (funct == 6'h10);
    assign is_mthi   = special && (funct == 6'h11);
    assign is_mflo   = special && (funct == 6'h12);
    assign is_mtlo   = special && (funct == 6'h13);
    assign is_arith  = special && (funct[5:2] == 4'b0110);   // 0x18..0x1B
    assign md_class  = is_mfhi | is_mthi | is_mflo | is_mtlo | is_arith;
    assign op_signed = ~funct[0];                            // MULT/DIV are the even codes

    logic unused_i2;
    assign unused_i2 = ^I2[25:6];

    assign MDbusy  = (state != IDLE);
    assign MDstall = I2Valid & md_class & MDbusy;
    assign accept  = I2Valid & md_class & ~MDbusy & ~ExHold;

    always_comb begin
        MDresult = 32'd0;
        if (I2Valid && is_mfhi)      MDresult = hi;
        else if (I2Valid && is_mflo) MDresult = lo;
    end

    // ---------------- operand magnitudes ----------------
    logic [31:0] rs_mag, rt_mag;
    assign rs_mag = (op_signed && RSbus[31]) ? (~RSbus + 32'd1) : RSbus;
    assign rt_mag = (op_signed && RTbus[31]) ? (~RTbus + 32'd1) : RTbus;

    // ---------------- iteration datapath ----------------
    // Shift-add: add multiplicand into the upper half, then shift the whole accumulator right.
    logic [32:0] psum;
    assign psum = {1'b0, acc[63:32]} + (b[0] ? {1'b0, a} : 33'd0);

    // Restoring divide: partial remainder shifted left with the next dividend bit.
    logic [32:0] rem33, diff;
    logic        ge;
    logic [31:0] newrem;
    assign rem33  = {acc[63:32], a[31]};
    assign ge     = (rem33 >= {1'b0, b});
    assign diff   = rem33 - {1'b0, b};
    assign newrem = ge ? diff[31:0] : rem33[31:0];

    // ---------------- sign fixup ----------------
    // With a zero divisor every trial subtract succeeds, so the remainder ends up as |rs|;
    // re-applying sign(rs) to it restores the original rs exactly.
    logic [63:0] acc_neg;
    logic [31:0] rem_neg, quo_neg, fix_hi, fix_lo;
    assign acc_neg = ~acc + 64'd1;
    assign rem_neg = ~acc[63:32] + 32'd1;
    assign quo_neg = ~acc[31:0] + 32'd1;

    always_comb begin
        fix_hi = neg_q ? acc_neg[63:32] : acc[63:32];
        fix_lo = neg_q ? acc_neg[31:0]  : acc[31:0];
        if (div_op) begin
            fix_hi = neg_r ? rem_neg : acc[63:32];
            fix_lo = dz ? 32'hFFFF_FFFF : (neg_q ? quo_neg : acc[31:0]);
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            hi     <= 32'd0;
            lo     <= 32'd0;
            a      <= 32'd0;
            b      <= 32'd0;
            acc    <= 64'd0;
            cnt    <= 5'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            div_op <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mthi) hi <= RSbus;
                        if (is_mtlo) lo <= RSbus;
                        if (is_arith) begin
                            state  <= funct[1] ? DIV : MUL;
                            a      <= rs_mag;
                            b      <= rt_mag;
                            neg_q  <= op_signed & (RSbus[31] ^ RTbus[31]);
                            neg_r  <= op_signed & RSbus[31];
                            dz     <= (RTbus == 32'd0);
                            div_op <= funct[1];
                            acc    <= 64'd0;
                            cnt    <= 5'd0;
                        end
                    end
                end
                MUL: begin
                    acc <= {psum, acc[31:1]};
                    b   <= {1'b0, b[31:1]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                DIV: begin
                    acc <= {newrem, acc[30:0], ge};
                    a   <= {a[30:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: latency, signed/unsigned results, divide by zero, moves, hold, reset.
// Inputs are driven #1 after the rising edge; outputs are sampled at that same point.
// Every check is an immediate assertion counted in ntests / nfail.
module tb_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] I2;
    logic        I2Valid;
    logic        ExHold;
    logic [31:0] RSbus;
    logic [31:0] RTbus;
    logic [31:0] MDresult;
    logic        MDbusy;
    logic        MDstall;

    int ntests = 0;
    int nfail  = 0;

    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADDU = 6'h21;

    muldiv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .I2       (I2),
        .I2Valid  (I2Valid),
        .ExHold   (ExHold),
        .RSbus    (RSbus),
        .RTbus    (RTbus),
        .MDresult (MDresult),
        .MDbusy   (MDbusy),
        .MDstall  (MDstall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        I2      = {6'd0, 20'd0, f};
        I2Valid = 1'b1;
        RSbus   = rs;
        RTbus   = rt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue an arithmetic op, then put MFHI in EX behind it and count stall cycles.
    // Leaves MFHI in EX, unit idle, so the caller can read HI then LO.
    task automatic run_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                          output int stalls);
        drive(f, rs, rt);
        step();
        drive(F_MFHI, 32'd0, 32'd0);
        stalls = 0;
        while (MDstall && stalls < 100) begin
            stalls++;
            step();
        end
    endtask

    task automatic op_case(input string tag, input logic [5:0] f, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
        int st;
        run_op(f, rs, rt, st);
        check({tag, " stall cycles"}, st, 32'd33);
        check({tag, " HI"}, MDresult, exp_hi);
        drive(F_MFLO, 32'd0, 32'd0);
        #1;
        check({tag, " LO"}, MDresult, exp_lo);
        I2Valid = 1'b0;
        step();
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        I2      = 32'd0;
        I2Valid = 1'b0;
        ExHold  = 1'b0;
        RSbus   = 32'd0;
        RTbus   = 32'd0;
        #1;
        drive(F_MFHI, 32'd0, 32'd0);
        #1;
        check("reset busy", {31'd0, MDbusy}, 32'd0);
        check("reset stall", {31'd0, MDstall}, 32'd0);
        check("reset HI", MDresult, 32'd0);
        drive(F_MFLO, 32'd0, 32'd0);
        #1;
        check("reset LO", MDresult, 32'd0);
        I2Valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        op_case("MULT -1*2",   F_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE);
        op_case("MULTU max*2", F_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE);
        op_case("MULT -3*-4",  F_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_000C);
        op_case("DIV -7/2",    F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        op_case("DIV min/-1",  F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        op_case("DIVU 100/7",  F_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E);
        op_case("DIVU 7/0",    F_DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF);
        op_case("DIV -5/0",    F_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // MTLO then MFLO on the very next cycle
        drive(F_MTLO, 32'h1234_5678, 32'd0);
        #1;
        check("MTLO stall", {31'd0, MDstall}, 32'd0);
        step();
        drive(F_MFLO, 32'd0, 32'd0);
        #1;
        check("MFLO after MTLO stall", {31'd0, MDstall}, 32'd0);
        check("MFLO after MTLO", MDresult, 32'h1234_5678);

        // ADDU during busy: no stall; HI keeps its old value during iteration
        drive(F_MULTU, 32'd3, 32'd5);
        step();
        drive(F_ADDU, 32'd1, 32'd1);
        #1;
        check("ADDU busy", {31'd0, MDbusy}, 32'd1);
        check("ADDU stall", {31'd0, MDstall}, 32'd0);
        check("ADDU result", MDresult, 32'd0);
        step();
        step();
        drive(F_MFHI, 32'd0, 32'd0);
        #1;
        check("HI held mid-op", MDresult, 32'hFFFF_FFFB);
        I2Valid = 1'b0;
        n = 0;
        while (MDbusy && n < 100) begin
            n++;
            step();
        end
        check("MULTU 3*5 finishes", {31'd0, MDbusy}, 32'd0);
        drive(F_MFLO, 32'd0, 32'd0);
        #1;
        check("MULTU 3*5 LO", MDresult, 32'd15);

        // MTHI under ExHold: no accept, no stall
        ExHold = 1'b1;
        drive(F_MTHI, 32'hCAFE_F00D, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold stall", {31'd0, MDstall}, 32'd0);
            step();
        end
        drive(F_MFHI, 32'd0, 32'd0);
        #1;
        check("HI during hold", MDresult, 32'h0000_0000);
        drive(F_MTHI, 32'hCAFE_F00D, 32'd0);
        ExHold = 1'b0;
        step();
        drive(F_MFHI, 32'd0, 32'd0);
        #1;
        check("HI after hold", MDresult, 32'hCAFE_F00D);

        // Reset 10 cycles into a MULT
        drive(F_MULT, 32'hFFFF_FFFF, 32'd2);
        step();
        I2Valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("busy mid-MULT", {31'd0, MDbusy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("busy after reset", {31'd0, MDbusy}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        drive(F_MFHI, 32'd0, 32'd0);
        #1;
        check("HI after abort", MDresult, 32'd0);
        drive(F_MFLO, 32'd0, 32'd0);
        #1;
        check("LO after abort", MDresult, 32'd0);
        I2Valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
